// File: rtl/bist_fail_log.sv
// BIST miscompare logger: re-checks each BIST read and queues failing
// reads in a small FWFT FIFO, with a saturating fail count and sticky flags.
module bist_fail_log #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int PATTERN_WIDTH = 4,
  parameter int DEPTH         = 4,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic                     re,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [DATA_WIDTH-1:0]    check,
  input  logic [PATTERN_WIDTH-1:0] test_pattern,
  input  logic [DATA_WIDTH-1:0]    dout,
  output logic                     log_valid,
  input  logic                     log_ready,
  output logic [PATTERN_WIDTH-1:0] log_pattern,
  output logic [ADDR_WIDTH-1:0]    log_addr,
  output logic [DATA_WIDTH-1:0]    log_expected,
  output logic [DATA_WIDTH-1:0]    log_actual,
  output logic [$clog2(DEPTH):0]   log_level,
  output logic [COUNT_WIDTH-1:0]   fail_count,
  output logic                     overflow,
  output logic                     any_fail
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = PATTERN_WIDTH + ADDR_WIDTH + 2 * DATA_WIDTH;

  logic                     s_valid;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]    check_q;
  logic [PATTERN_WIDTH-1:0] pattern_q;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;

  logic fail;
  logic full;
  logic pop;
  logic push;

  assign fail = s_valid && (dout != check_q);
  assign full = (level == LW'(DEPTH));
  assign log_valid = (level != '0);
  assign pop  = log_valid && log_ready && !clear;
  // A full log still takes the entry when the head leaves this cycle.
  assign push = fail && !clear && (!full || pop);

  assign log_level = level;
  assign {log_pattern, log_addr, log_expected, log_actual} =
    log_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid   <= 1'b0;
      addr_q    <= '0;
      check_q   <= '0;
      pattern_q <= '0;
    end else if (clear) begin
      s_valid <= 1'b0;
    end else begin
      s_valid <= en && re;
      if (en && re) begin
        addr_q    <= addr;
        check_q   <= check;
        pattern_q <= test_pattern;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_count <= '0;
      overflow   <= 1'b0;
      any_fail   <= 1'b0;
    end else if (clear) begin
      fail_count <= '0;
      overflow   <= 1'b0;
      any_fail   <= 1'b0;
    end else if (fail) begin
      if (fail_count != '1) fail_count <= fail_count + 1'b1;
      any_fail <= 1'b1;
      if (!push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= {pattern_q, addr_q, check_q, dout};
    end
  end

endmodule

// File: doc/bist_fail_log.md
Name: bist_fail_log

Overview:
- Sits directly downstream of the BIST controller, on the same SRAM-side signals: the address, read-enable and expected-data stream the controller drives, plus the SRAM read data.
- Independently re-checks every BIST read and records each miscompare as a log entry: pattern, address, expected data, actual data.
- Entries go into a small first-word-fall-through (FWFT) FIFO, read out by a scan/debug host over a valid/ready handshake.
- Also keeps a saturating miscompare counter and a sticky overflow flag, so the host can diagnose failures beyond the BIST's single pass/fail bit.

Parameters:
- ADDR_WIDTH, 8, width of the SRAM address.
- DATA_WIDTH, 32, width of the SRAM data word.
- PATTERN_WIDTH, 4, width of the test-pattern selector.
- DEPTH, 4, number of log entries; must be a power of two and at least 2.
- COUNT_WIDTH, 8, width of the saturating fail counter.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- clear  input  1  synchronous clear of log, counter, overflow flag and pipeline
- en  input  1  capture enable (BIST enable)
- re  input  1  BIST read strobe
- addr  input  ADDR_WIDTH  BIST address
- check  input  DATA_WIDTH  expected read data
- test_pattern  input  PATTERN_WIDTH  active pattern
- dout  input  DATA_WIDTH  SRAM read data, valid the cycle after re
- log_valid  output  1  head entry present
- log_ready  input  1  host accepts head entry
- log_pattern  output  PATTERN_WIDTH  head entry pattern
- log_addr  output  ADDR_WIDTH  head entry address
- log_expected  output  DATA_WIDTH  head entry expected data
- log_actual  output  DATA_WIDTH  head entry actual data
- log_level  output  $clog2(DEPTH)+1  FIFO occupancy
- fail_count  output  COUNT_WIDTH  saturating miscompare count
- overflow  output  1  sticky: a miscompare was dropped because the log was full
- any_fail  output  1  sticky: at least one miscompare seen

Behaviour:
- Reset (rst high, asynchronous):
  - Pipeline valid bit, FIFO pointers, fail_count, overflow and any_fail all clear.
  - All log_* outputs read 0; log_valid=0, log_level=0.
- Capture stage, cycle N:
  - Registers addr, check and test_pattern into a one-deep stage when en&&re.
  - Its valid bit is set to en&&re every cycle.
- Compare stage, cycle N+1:
  - A fail event occurs when stage valid && dout != check_q.
  - The compare completes even if en has dropped in cycle N+1; the read is already in flight.
- Fail event handling:
  - fail_count increments, saturating at all-ones with no wrap.
  - any_fail is set.
  - The entry {pattern_q, addr_q, check_q, dout} is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the entry is dropped and overflow is set.
- FIFO:
  - FWFT: log_* outputs reflect the head entry combinationally from storage; log_valid = level != 0.
  - Pop when log_valid && log_ready. log_ready with an empty FIFO has no effect.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo DEPTH.
  - log_* fields are 0 while empty.
- Timing:
  - Latency from a failing read's re to log_valid is 2 cycles when the FIFO is empty: the entry is written at the N+1 edge and visible at N+2.
  - Back-to-back failing reads, one per cycle, log one entry per cycle.
- clear (synchronous) has priority over every same-cycle event:
  - Empties the FIFO, zeroes fail_count, overflow and any_fail, and invalidates the capture stage.
  - A miscompare in the clear cycle is discarded.
- rst asserted mid-operation discards all state immediately; no partial entry survives.
- No combinational path from log_ready to any output other than through registered state.

Test Plan:
1. Basic fail capture:
   - Stimulus: reset, en=1; re at addr=0x05, check=0xA5A5A5A5, pattern=1; next cycle dout=0xA5A5A5A4.
   - Response: two cycles after re, log_valid=1, log_addr=0x05, log_expected=0xA5A5A5A5, log_actual=0xA5A5A5A4, log_pattern=1, fail_count=1, any_fail=1.
2. Passing reads:
   - Stimulus: 16 reads with dout==check.
   - Response: log_valid=0, fail_count=0, any_fail=0.
3. Overflow:
   - Stimulus: 6 consecutive failing reads to addr 0..5 with log_ready=0.
   - Response: log_level=4, entries hold addr 0..3 in order, fail_count=6, overflow=1.
4. Full FIFO with simultaneous pop:
   - Stimulus: FIFO full (4 entries); failing read whose compare cycle coincides with log_ready=1.
   - Response: head popped, new entry accepted, log_level stays 4, overflow stays 0.
5. Counter saturation and clear:
   - Stimulus: 300 failing reads, then clear asserted in the same cycle as another miscompare.
   - Response: fail_count holds 255 before clear; after clear, fail_count=0, log_level=0, overflow=0, and no entry is logged.
6. Asynchronous reset:
   - Stimulus: rst pulsed between re and its compare cycle.
   - Response: all outputs 0 immediately, and no entry is logged after rst is released.
